stats_sequencer: RTL and testbench

STATS_SEQUENCER -- requirements
Module: stats_sequencer

---
 rtl/stats_sequencer_pkg.sv | 24 ++
 rtl/stats_sequencer_sat_counter.sv | 25 ++
 rtl/stats_sequencer.sv | 112 +++++++++++
 tb/tb_stats_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stats_sequencer_pkg.sv
// Shared definitions for the cache statistics sequencer: FSM encoding,
// dump word indices and the number of live counters.
package stats_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int NUM_CNT = 7;
    localparam int IDX_W   = 3;

    localparam logic [IDX_W-1:0] IDX_INS_READ   = 3'd0;
    localparam logic [IDX_W-1:0] IDX_INS_HIT    = 3'd1;
    localparam logic [IDX_W-1:0] IDX_INS_MISS   = 3'd2;
    localparam logic [IDX_W-1:0] IDX_DATA_READ  = 3'd3;
    localparam logic [IDX_W-1:0] IDX_DATA_WRITE = 3'd4;
    localparam logic [IDX_W-1:0] IDX_DATA_HIT   = 3'd5;
    localparam logic [IDX_W-1:0] IDX_DATA_MISS  = 3'd6;
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_DATA_MISS;

endpackage

// File: rtl/stats_sequencer_sat_counter.sv
// Saturating event counter: clear has priority over increment, and the
// count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/stats_sequencer.sv
// Seven saturating cache-event counters with a snapshot-and-dump sequencer
// that streams the frozen values out over a valid/ready port.
module stats_sequencer
    import stats_sequencer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ev_ins_read,
    input  logic             ev_ins_hit,
    input  logic             ev_ins_miss,
    input  logic             ev_data_read,
    input  logic             ev_data_write,
    input  logic             ev_data_hit,
    input  logic             ev_data_miss,
    input  logic             clear_req,
    input  logic             dump_req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_data,
    output logic             busy,
    output logic             dump_done,
    output state_t           dbg_state
);

    logic [NUM_CNT-1:0] ev;
    logic [CNT_W-1:0]   live [NUM_CNT];
    logic [CNT_W-1:0]   snap [NUM_CNT];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign ev[IDX_INS_READ]   = ev_ins_read;
    assign ev[IDX_INS_HIT]    = ev_ins_hit;
    assign ev[IDX_INS_MISS]   = ev_ins_miss;
    assign ev[IDX_DATA_READ]  = ev_data_read;
    assign ev[IDX_DATA_WRITE] = ev_data_write;
    assign ev[IDX_DATA_HIT]   = ev_data_hit;
    assign ev[IDX_DATA_MISS]  = ev_data_miss;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (ev[i]),
            .clr   (clear_req),
            .count (live[i])
        );
    end

    // Snapshot takes the registered live values, so same-cycle events land
    // in the live counters only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) snap[i] <= '0;
        end else if (state_q == ST_SNAP) begin
            for (int i = 0; i < NUM_CNT; i++) snap[i] <= live[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Output handshake: a word transfers on any rising edge where out_valid
    // and out_ready are both high; until then out_idx/out_data hold steady.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: if (dump_req) state_d = ST_SNAP;
            ST_SNAP: begin
                state_d = ST_SEND;
                idx_d   = '0;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = (state_q == ST_SEND);
    assign out_idx   = out_valid ? idx_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign dump_done = (state_q == ST_DONE);
    assign dbg_state = state_q;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (out_valid && (idx_q == IDX_W'(i))) out_data = snap[i];
        end
    end

endmodule

// File: tb/tb_stats_sequencer.sv
// Bench for stats_sequencer: table-driven dumps, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_stats_sequencer;
    import stats_sequencer_pkg::*;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int M_IDLE = 0, M_SNAP = 1, M_SEND = 2, M_DONE = 3;
    localparam logic [6:0] E_IR  = 7'b0000001;
    localparam logic [6:0] E_DR  = 7'b0001000;
    localparam logic [6:0] E_DM  = 7'b1000000;
    localparam logic [6:0] E_ALL = 7'b1111111;

    logic clk = 1'b0, reset = 1'b1;
    logic ev_ins_read, ev_ins_hit, ev_ins_miss;
    logic ev_data_read, ev_data_write, ev_data_hit, ev_data_miss;
    logic clear_req, dump_req, out_ready;
    logic out_valid, busy, dump_done;
    logic [2:0]   out_idx;
    logic [W-1:0] out_data;
    state_t       dbg_state;

    stats_sequencer #(.CNT_W(W)) dut (
        .clk(clk), .reset(reset),
        .ev_ins_read(ev_ins_read), .ev_ins_hit(ev_ins_hit), .ev_ins_miss(ev_ins_miss),
        .ev_data_read(ev_data_read), .ev_data_write(ev_data_write),
        .ev_data_hit(ev_data_hit), .ev_data_miss(ev_data_miss),
        .clear_req(clear_req), .dump_req(dump_req), .out_ready(out_ready),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
        .busy(busy), .dump_done(dump_done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int m_live [7];
    int m_phase, m_left;
    logic [W+2:0] exp_q[$];
    int got [8];
    int done_cnt = 0;

    typedef struct packed {
        logic [6:0][4:0]   reps;   // element 6 (data_miss) is leftmost
        logic              toggle;
        logic [6:0][W-1:0] exp;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_live[i] = 0;
        m_phase = M_IDLE;
        m_left  = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic [6:0] ev, input logic clr, input logic dmp, input logic rdy);
        {ev_data_miss, ev_data_hit, ev_data_write, ev_data_read,
         ev_ins_miss, ev_ins_hit, ev_ins_read} = ev;
        clear_req = clr;
        dump_req  = dmp;
        out_ready = rdy;
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance model at the edge.
    task automatic step(input logic [6:0] ev, input logic clr, input logic dmp, input logic rdy);
        logic [W+2:0] front;
        drive(ev, clr, dmp, rdy);
        #1;
        chk("out_valid", out_valid, int'(m_phase == M_SEND));
        chk("busy", busy, int'(m_phase != M_IDLE));
        chk("dump_done", dump_done, int'(m_phase == M_DONE));
        if (dump_done) done_cnt++;
        if (m_phase == M_SEND) begin
            if (exp_q.size() == 0) begin
                chk("exp_q_empty", 1, 0);
            end else begin
                front = exp_q[0];
                chk("out_idx", out_idx, front[W+2:W]);
                chk("out_data", out_data, front[W-1:0]);
                if (rdy) begin
                    got[out_idx] = out_data;
                    void'(exp_q.pop_front());
                end
            end
        end else begin
            chk("out_idx_idle", out_idx, 0);
            chk("out_data_idle", out_data, 0);
        end
        @(posedge clk);
        case (m_phase)
            M_IDLE: if (dmp) m_phase = M_SNAP;
            M_SNAP: begin
                for (int i = 0; i < 7; i++) exp_q.push_back({3'(i), W'(m_live[i])});
                m_left  = 7;
                m_phase = M_SEND;
            end
            M_SEND: if (rdy) begin
                m_left--;
                if (m_left == 0) m_phase = M_DONE;
            end
            default: m_phase = M_IDLE;
        endcase
        for (int i = 0; i < 7; i++) begin
            if (clr) m_live[i] = 0;
            else if (ev[i] && m_live[i] < MAXV) m_live[i]++;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(7'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dump_done", dump_done, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_dump(input bit toggle, input logic [6:0] ev_during);
        logic rdy;
        int n;
        for (int i = 0; i < 8; i++) got[i] = -1;
        step(7'd0, 1'b0, 1'b1, 1'b1);
        rdy = 1'b1;
        n = 0;
        while (m_phase != M_IDLE && n < 40) begin
            step(ev_during, 1'b0, 1'b0, rdy);
            if (toggle && m_phase == M_SEND) rdy = ~rdy;
            n++;
        end
        if (m_phase != M_IDLE) chk("dump_timeout", 1, 0);
    endtask

    task automatic pulse(input logic [6:0][4:0] reps);
        logic [6:0] ev;
        for (int c = 0; c < 32; c++) begin
            for (int i = 0; i < 7; i++) ev[i] = (int'(reps[i]) > c);
            if (ev != 7'd0) step(ev, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        int d0;
        logic [6:0] rev;
        tbl[0] = '{reps: {5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0}, toggle: 1'b0,
                   exp:  {4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0}};
        tbl[1] = '{reps: {5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4}, toggle: 1'b1,
                   exp:  {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4}};
        tbl[2] = '{reps: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd17}, toggle: 1'b0,
                   exp:  {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15}};
        tbl[3] = '{reps: {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, toggle: 1'b1,
                   exp:  {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}};
        tbl[4] = '{reps: {5'd0, 5'd31, 5'd16, 5'd15, 5'd14, 5'd0, 5'd0}, toggle: 1'b0,
                   exp:  {4'd0, 4'd15, 4'd15, 4'd15, 4'd14, 4'd0, 4'd0}};

        apply_reset();
        for (int k = 0; k < 5; k++) begin
            apply_reset();
            pulse(tbl[k].reps);
            d0 = done_cnt;
            do_dump(tbl[k].toggle, 7'd0);
            for (int i = 0; i < 7; i++) chk($sformatf("tbl%0d_word%0d", k, i), got[i], int'(tbl[k].exp[i]));
            chk($sformatf("tbl%0d_done_pulses", k), done_cnt - d0, 1);
        end

        // Events in SNAP and during SEND miss the current dump, show in the next.
        apply_reset();
        repeat (10) step(E_DR, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) got[i] = -1;
        step(7'd0, 1'b0, 1'b1, 1'b1);
        step(E_DR, 1'b0, 1'b0, 1'b1);
        step(E_DR, 1'b0, 1'b0, 1'b1);
        step(E_DR, 1'b0, 1'b0, 1'b1);
        repeat (8) step(7'd0, 1'b0, 1'b0, 1'b1);
        chk("snap_first_dump", got[3], 10);
        do_dump(1'b0, 7'd0);
        chk("snap_second_dump", got[3], 13);

        // Clear beats a same-cycle strobe; clear mid-dump spares the snapshot.
        apply_reset();
        repeat (7) step(E_IR, 1'b0, 1'b0, 1'b1);
        step(E_IR, 1'b1, 1'b0, 1'b1);
        do_dump(1'b0, 7'd0);
        chk("clear_wins", got[0], 0);
        repeat (5) step(E_DM, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) got[i] = -1;
        step(7'd0, 1'b0, 1'b1, 1'b1);
        step(7'd0, 1'b0, 1'b0, 1'b1);
        step(7'd0, 1'b0, 1'b0, 1'b1);
        step(7'd0, 1'b1, 1'b0, 1'b1);
        repeat (8) step(7'd0, 1'b0, 1'b0, 1'b1);
        chk("clear_mid_dump_word", got[6], 5);
        do_dump(1'b0, 7'd0);
        chk("after_clear_dump", got[6], 0);

        // Reset while word 3 is on the port.
        apply_reset();
        repeat (3) step(E_ALL, 1'b0, 1'b0, 1'b1);
        step(7'd0, 1'b0, 1'b1, 1'b1);
        repeat (4) step(7'd0, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_idx", out_idx, 3);
        d0 = done_cnt;
        apply_reset();
        repeat (12) step(7'd0, 1'b0, 1'b0, 1'b1);
        chk("no_done_after_abort", done_cnt - d0, 0);
        do_dump(1'b0, 7'd0);
        for (int i = 0; i < 7; i++) chk($sformatf("post_reset_word%0d", i), got[i], 0);

        // Randomized traffic against the model.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 7; i++) rev[i] = ($urandom_range(0, 3) == 0);
            step(rev, ($urandom_range(0, 40) == 0), ($urandom_range(0, 8) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
